// File: rtl/icache_refill_ctrl_pkg.sv
// Shared instruction-fetch defines: bus widths, refill line geometry and the
// refill controller state encoding.
package icache_refill_ctrl_pkg;

    localparam int unsigned INST_ADDR_BUS_W = 64;
    localparam int unsigned INST_BUS_W      = 32;

    // 64-byte line of 4-byte instructions
    localparam int unsigned ICACHE_LINE_WORDS = 16;
    localparam int unsigned LINE_OFFSET_W     = 6;
    localparam logic [INST_ADDR_BUS_W-1:0] LINE_OFFSET_MASK =
        {{(INST_ADDR_BUS_W-LINE_OFFSET_W){1'b1}}, {LINE_OFFSET_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FLUSH = 3'd4
    } refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction cache line refill controller: fetches one line word by word with a
// single outstanding bus read and handles fence.i invalidation.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int unsigned ADDR_W     = INST_ADDR_BUS_W,
    parameter int unsigned INST_W     = INST_BUS_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] PcIn,
    input  logic              CacheMissing,
    input  logic              CacheFull,
    input  logic              FlushReq,
    output logic              BusReadValid,
    output logic [ADDR_W-1:0] BusReadAddr,
    input  logic              BusReadReady,
    input  logic              BusDataValid,
    input  logic [INST_W-1:0] BusDataIn,
    output logic [ADDR_W-1:0] PrePcOut,
    output logic [INST_W-1:0] InstOut,
    output logic              ReadShakeHands,
    output logic              CacheInvalidate,
    output logic              RefillBusy,
    output logic              StallReq
);

    localparam int unsigned CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADDR_W-1:0] BASE_MASK = ADDR_W'(LINE_OFFSET_MASK);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(LINE_WORDS - 1);

    refill_state_t     state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic              flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0] pre_pc_q;
    logic [INST_W-1:0] inst_q;
    logic              wr_stb_q;
    logic [ADDR_W-1:0] beat_addr;
    logic              load_base, cnt_inc, write_beat;

    // Base has its offset bits cleared, so the word offset never carries upward.
    assign beat_addr = base_q + ADDR_W'({word_cnt_q, 2'b00});

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        load_base    = 1'b0;
        cnt_inc      = 1'b0;
        write_beat   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                flush_pend_d = 1'b0;
                if (FlushReq) begin
                    state_d = ST_FLUSH;
                end else if (CacheMissing || !CacheFull) begin
                    load_base = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (FlushReq) flush_pend_d = 1'b1;
                if (BusReadReady) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (FlushReq) flush_pend_d = 1'b1;
                if (BusDataValid) begin
                    // A flush seen during this read drops the beat instead of writing it.
                    if (flush_pend_q || FlushReq) begin
                        state_d = ST_FLUSH;
                    end else begin
                        write_beat = 1'b1;
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_inc = 1'b1;
                            state_d = ST_ADDR;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FLUSH: begin
                flush_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            word_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            pre_pc_q     <= '0;
            inst_q       <= '0;
            wr_stb_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            wr_stb_q     <= write_beat;
            if (load_base) begin
                base_q     <= PcIn & BASE_MASK;
                word_cnt_q <= '0;
            end else if (cnt_inc) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
            if (write_beat) begin
                pre_pc_q <= beat_addr;
                inst_q   <= BusDataIn;
            end
        end
    end

    assign BusReadValid    = (state_q == ST_ADDR);
    assign BusReadAddr     = BusReadValid ? beat_addr : '0;
    assign PrePcOut        = pre_pc_q;
    assign InstOut         = inst_q;
    assign ReadShakeHands  = wr_stb_q;
    assign CacheInvalidate = (state_q == ST_FLUSH);
    assign RefillBusy      = (state_q != ST_IDLE);
    assign StallReq        = RefillBusy | CacheMissing;

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16, instruction words per refill (64-byte cache / 4-byte words).
REQ-002 SHALL have parameter ADDR_W, default 64, instruction address width.
REQ-003 SHALL have parameter INST_W, default 32, instruction width.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  synchronous reset, active high.
REQ-005 SHALL have the remaining ports, in this order:
- PcIn  in  ADDR_W  fetch PC from Pc stage.
- CacheMissing  in  1  cache reports PcIn not resident.
- CacheFull  in  1  cache reports all entries valid.
- FlushReq  in  1  one-cycle fence.i/invalidate request.
- BusReadValid  out  1  read address valid.
- BusReadAddr  out  ADDR_W  read address, word aligned.
- BusReadReady  in  1  bus accepted address.
- BusDataValid  in  1  read data beat returned.
- BusDataIn  in  INST_W  read data.
- PrePcOut  out  ADDR_W  address written into cache.
- InstOut  out  INST_W  instruction written into cache.
- ReadShakeHands  out  1  one-cycle cache write strobe.
- CacheInvalidate  out  1  one-cycle clear of all cache valid bits.
- RefillBusy  out  1  high in any state other than IDLE.
- StallReq  out  1  to Ctrl; equals RefillBusy OR CacheMissing.

Function
REQ-006 SHALL implement FSM states IDLE, ADDR, DATA, DONE, FLUSH.
REQ-007 IDLE: if FlushReq, go to FLUSH; else if CacheMissing or not CacheFull, latch Base = PcIn with bits [5:0] cleared, clear WordCnt, go to ADDR; else stay.
REQ-008 FlushReq SHALL have priority over a refill start in the same IDLE cycle.
REQ-009 ADDR: BusReadValid = 1 and BusReadAddr = Base + 4*WordCnt; both SHALL stay stable until BusReadReady; on BusReadReady go to DATA.
REQ-010 DATA: BusReadValid = 0; on BusDataValid, register PrePcOut = Base + 4*WordCnt and InstOut = BusDataIn, and pulse ReadShakeHands high for exactly the next cycle.
REQ-011 After a DATA beat: if WordCnt == LINE_WORDS-1 go to DONE, else increment WordCnt and go to ADDR; at most one read is outstanding.
REQ-012 WordCnt SHALL be $clog2(LINE_WORDS) bits; address arithmetic is modulo 2^ADDR_W; Base upper bits are never altered by WordCnt.
REQ-013 DONE SHALL last one cycle, then go to IDLE.
REQ-014 FLUSH SHALL assert CacheInvalidate for exactly one cycle, then go to IDLE.
REQ-015 FlushReq in ADDR or DATA SHALL set a sticky FlushPend. The in-flight address/data pair completes per the bus protocol, but its beat is NOT written (no ReadShakeHands). The FSM then goes to FLUSH instead of ADDR/DONE.
REQ-016 The refill SHALL ignore pipeline hold flags; PcIn changes after the start of a refill SHALL NOT affect Base.
REQ-017 BusDataValid outside DATA SHALL be ignored.

Reset
REQ-018 On Rst: state = IDLE; WordCnt, Base, FlushPend = 0; every output = 0 (PrePcOut = 0, InstOut = 0).
REQ-019 Rst asserted mid-refill SHALL drop BusReadValid the following cycle, with no write strobe and no invalidate.

Structure
REQ-020 State encoding, LINE_WORDS, and the line-offset mask SHALL live in the shared defines/package next to InstAddrBus/InstBus.
REQ-021 The block SHALL be a single module with no sub-modules; the beat-address adder is inline.

Verification
REQ-022 Cold start: CacheFull=0, PcIn=0x8000_0044, BusReadReady and BusDataValid each one cycle after request -> 16 addresses 0x8000_0040..0x8000_007C in order, 16 ReadShakeHands pulses, then DONE then IDLE.
REQ-023 Backpressure: BusReadReady held low 5 cycles in ADDR -> BusReadValid/BusReadAddr constant for all 5 cycles, no strobe.
REQ-024 Miss with PcIn changing mid-refill (0x8000_0100 -> 0x8000_0200) -> all beats use Base 0x8000_0100.
REQ-025 FlushReq at beat 7 in DATA -> beat 7 completes on bus, no strobe for it, CacheInvalidate pulses once, FSM returns to IDLE, then refills again if CacheFull=0.
REQ-026 FlushReq and CacheMissing together in IDLE -> FLUSH first (one CacheInvalidate), then refill.
REQ-027 Rst in DATA at beat 3 -> next cycle all outputs 0, state IDLE, no further strobes.
